ram_poll_reader: RTL

//  Read-side counterpart of the switch-to-RAM writer. Periodically reads one fixed
//  RAM word (the switch mailbox at address 562) through the synchronous read port.

---
 rtl/ram_poll_reader_if.sv | 44 ++++
 rtl/ram_poll_reader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ram_poll_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_poll_reader_if
// Purpose  : Bundles the RAM read port and the sample-consumer handshake of
//            ram_poll_reader.
// Signals  : ram_addr     RAM read address (reader -> RAM)
//            ram_re       one-cycle read strobe (reader -> RAM)
//            ram_rdata    RAM read data (RAM -> reader)
//            ram_wr_busy  writer's write enable; blocks read issue
//            poll_now     request an immediate poll
//            data_out     sample presented to the consumer
//            data_valid   data_out valid
//            data_ready   consumer accepts data_out
//            data_changed data_out differs from the last accepted sample
//            overrun      sticky: an automatic poll tick was dropped
// Modports : master = reader side, slave = RAM/consumer side
// Revision : 1.0 - initial release
// ============================================================================
interface ram_poll_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_wr_busy;
  logic              poll_now;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              data_changed;
  logic              overrun;

  modport master (
    output ram_addr, ram_re, data_out, data_valid, data_changed, overrun,
    input  ram_rdata, ram_wr_busy, poll_now, data_ready
  );

  modport slave (
    input  ram_addr, ram_re, data_out, data_valid, data_changed, overrun,
    output ram_rdata, ram_wr_busy, poll_now, data_ready
  );
endinterface
`default_nettype wire

// File: rtl/ram_poll_reader.sv
`default_nettype none
// ============================================================================
// Module   : ram_poll_reader
// Purpose  : Periodically reads the switch mailbox word at POLL_ADDR through a
//            synchronous RAM read port and hands each sample to a consumer
//            over a valid/ready handshake. Reads are deferred while the writer
//            is active; automatic polls that arrive while busy are dropped and
//            flagged on the sticky overrun output.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous reset, active-high
//            bus  - ram_poll_reader_if.master (RAM read port + consumer side)
// Options  : POLL_CHANGE_FILTER_EN - when defined, a sample equal to the last
//            accepted one is not presented (only first/new values reach the
//            consumer).
// Revision : 1.0 - initial release
// ============================================================================
module ram_poll_reader #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int POLL_ADDR = 562,
  parameter int POLL_DIV  = 1000,
  parameter int RD_LAT    = 1
) (
  input wire                 clk,
  input wire                 rst,
  ram_poll_reader_if.master  bus
);

  localparam int DIV_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [DIV_W-1:0]  c_DIV_LAST  = DIV_W'(POLL_DIV - 1);
  localparam logic [LAT_W-1:0]  c_LAT_INIT  = LAT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] c_POLL_ADDR = ADDR_W'(POLL_ADDR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [LAT_W-1:0]    r_lat_cnt;
  logic [DATA_W-1:0]   r_data_out;
  logic [DATA_W-1:0]   r_last_val;
  logic                r_first;
  logic                r_changed;
  logic                r_overrun;

  logic                w_tick;
  logic                w_ram_re;
  logic                w_capture;
  logic                w_accept;
  logic                w_skip;
  logic                w_changed_new;

  assign w_tick        = (r_div_cnt == c_DIV_LAST);
  assign w_changed_new = (bus.ram_rdata != r_last_val) | r_first;

`ifdef POLL_CHANGE_FILTER_EN
  // A repeat of the last accepted value is swallowed; data_out already holds
  // that value, so capturing it anyway leaves the outputs unchanged.
  assign w_skip = ~r_first & (bus.ram_rdata == r_last_val);
`else
  assign w_skip = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and strobes
  always_comb begin
    w_state_nxt = r_state;
    w_ram_re    = 1'b0;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // tick and poll_now together still yield a single poll
        if (w_tick || bus.poll_now) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // retry every cycle until the writer releases the RAM
        if (!bus.ram_wr_busy) begin
          w_ram_re    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // lat_cnt reaches zero exactly RD_LAT cycles after ram_re
        if (r_lat_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = w_skip ? S_IDLE : S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.data_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Divider, latency counter and sample datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt  <= '0;
      r_lat_cnt  <= '0;
      r_data_out <= '0;
      r_last_val <= '0;
      r_first    <= 1'b1;
      r_changed  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_div_cnt <= w_tick ? '0 : (r_div_cnt + DIV_W'(1));

      // any tick outside IDLE is lost, including one coinciding with accept
      if (w_tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end

      if (w_ram_re) begin
        r_lat_cnt <= c_LAT_INIT;
      end else if ((r_state == S_WAIT) && (r_lat_cnt != '0)) begin
        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
      end

      if (w_capture) begin
        r_data_out <= bus.ram_rdata;
        r_changed  <= w_changed_new;
      end

      if (w_accept) begin
        r_last_val <= r_data_out;
        r_first    <= 1'b0;
        r_changed  <= 1'b0;
      end
    end
  end

  assign bus.ram_addr     = c_POLL_ADDR;
  assign bus.ram_re       = w_ram_re;
  assign bus.data_out     = r_data_out;
  assign bus.data_valid   = (r_state == S_HOLD);
  assign bus.data_changed = r_changed;
  assign bus.overrun      = r_overrun;

endmodule
`default_nettype wire
